mips_mult_div: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the two register-file read ports (rs, rt) directly downstream of the register file.
- Executes MULT, MULTU, DIV and DIVU in a fixed 33-cycle sequence.
- Also services MTHI/MTLO writes; HI/LO feed the MFHI/MFLO writeback mux.

---
 rtl/mips_mult_div.sv | 136 +++++++++++++
 tb/tb_mips_mult_div.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mult_div.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract; every
// operation takes a fixed 33 cycles (32 iterations plus one sign-fix cycle).
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO writes accepted here
//   CALC  | one multiply/divide iteration per cycle, 32 cycles
//   FIX   | sign correction and HI/LO update, done pulse
module mips_mult_div #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] write_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   a_raw;

   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Operand magnitudes and one iteration of each datapath.
   // acc holds {partial product, multiplier} for multiply and
   // {remainder, dividend/quotient} for divide; addend is the multiplicand
   // or divisor. abs of 0x80000000 wraps to itself, which reads as 2^31.
   always_comb begin
      sign_a    = ~op[0] & operand_a[WIDTH-1];
      sign_b    = ~op[0] & operand_b[WIDTH-1];
      abs_a     = sign_a ? -operand_a : operand_a;
      abs_b     = sign_b ? -operand_b : operand_b;
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, addend};
      div_ge    = ~div_diff[WIDTH];
      div_next  = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      prod_fix  = neg_q ? -acc : acc;
      quot_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Sequencer, datapath registers and HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         acc      <= '0;
         addend   <= '0;
         a_raw    <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  neg_q    <= sign_a ^ sign_b;
                  neg_r    <= sign_a;
                  addend   <= op[1] ? abs_b : abs_a;
                  acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                  a_raw    <= operand_a;
                  div_zero <= op[1] && (operand_b == '0);
                  cnt      <= '1;
                  busy     <= 1'b1;
                  state    <= CALC;
               end else begin
                  if (hi_we) hi <= write_data;
                  if (lo_we) lo <= write_data;
               end
            end
            CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               if (!is_div) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else if (div_zero) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mult_div.sv
// Bench for mips_mult_div: stimulus pushes expected HI/LO/div_zero into a
// queue, a monitor pops and compares on every done pulse.
module tb_mips_mult_div;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] write_data = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   busy_cnt = 0;

   mips_mult_div #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .hi_we(hi_we), .lo_we(lo_we), .write_data(write_data),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: MIPS semantics via 64-bit integer arithmetic.
   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, p, q, r;
      if (o[0] == 1'b0) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      e.dz = o[1] && (b == 32'h0);
      if (!o[1]) begin
         p    = sa * sb;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == 32'h0) begin
         e.hi = a;
         e.lo = 32'hFFFF_FFFF;
      end else begin
         q    = sa / sb;
         r    = sa % sb;
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      return e;
   endfunction

   // Called just after a negedge with the DUT idle; start is accepted at the next edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      exp_q.push_back(model(o, a, b));
      @(negedge clk);
      start     = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      op        = 2'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL done_timeout actual=no_done required=done_within_60");
         exp_q.delete();
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compare each completion with the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done actual=done required=no_done");
               end else begin
                  e = exp_q.pop_front();
                  check("result_hi", hi, e.hi);
                  check("result_lo", lo, e.lo);
                  check("div_zero", 32'(div_zero), 32'(e.dz));
                  check("busy_cycles", busy_cnt, 33);
                  check("busy_low_at_done", 32'(busy), 0);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   initial begin
      logic [1:0] ro;
      repeat (2) @(negedge clk);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_div_zero", 32'(div_zero), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed operations, back to back where the done pulse allows.
      issue(2'b00, 32'hFFFF_FFFD, 32'd5);          wait_done();
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done();
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);          wait_done();
      issue(2'b11, 32'd7, 32'd0);                  wait_done();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done();

      // Start and MTHI while busy are ignored; hi still holds the last result (0).
      @(negedge clk);
      issue(2'b11, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      start      = 1'b1;
      op         = 2'b00;
      operand_a  = 32'd5;
      operand_b  = 32'd9;
      hi_we      = 1'b1;
      write_data = 32'h0000_1234;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      check("busy_mthi_dropped", hi, 32'h0);
      check("busy_still_set", 32'(busy), 1);
      wait_done();

      // MTHI then MTLO in IDLE.
      @(negedge clk);
      hi_we      = 1'b1;
      write_data = 32'hA5A5_A5A5;
      @(negedge clk);
      check("mthi_hi", hi, 32'hA5A5_A5A5);
      check("mthi_lo_kept", lo, 32'd14);
      hi_we      = 1'b0;
      lo_we      = 1'b1;
      write_data = 32'h5A5A_5A5A;
      @(negedge clk);
      check("mtlo_lo", lo, 32'h5A5A_5A5A);
      check("mtlo_hi_kept", hi, 32'hA5A5_A5A5);
      lo_we = 1'b0;
      @(negedge clk);

      // start and MTLO in the same cycle: start wins.
      lo_we      = 1'b1;
      write_data = 32'hDEAD_BEEF;
      issue(2'b01, 32'd2, 32'd3);
      check("start_wins_lo", lo, 32'h5A5A_5A5A);
      wait_done();

      // Randomized back-to-back operations.
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         issue(ro, pick(), pick());
         wait_done();
      end

      // Asynchronous reset mid-operation.
      issue(2'b11, 32'd9, 32'd0);
      wait_done();
      issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (14) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_hi", hi, 0);
      check("async_rst_lo", lo, 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_done", 32'(done), 0);
      check("async_rst_div_zero", 32'(div_zero), 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2'b01, 32'd6, 32'd7);
      wait_done();
      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
